// File: rtl/uart_rx_pkg.sv
// Shared types and bit-index constants for the UART receive path.
package uart_rx_pkg;

  // Frame phases walked by the receive controller.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  // Bit indices as reported by the shared edge/bit counter.
  localparam int START_BIT     = 0;
  localparam int LAST_DATA_BIT = 8;
  localparam int PARITY_BIT    = 9;

endpackage

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for the UART receiver: walks START, DATA,
// PARITY and STOP, times the sampler/deserializer/checker strobes from the
// shared counter and reports one data_valid or frame_err pulse per frame.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  bit_cnt,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_en,
  output logic                  new_frame,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  par_err_o,
  output logic                  stp_err_o
);

  rx_state_e state_q, state_d;

  logic par_en_q;
  logic glitch_q;
  logic par_err_q;
  logic stp_err_q;

  // Check point is the first edge after the 3-sample majority window.
  logic [PRESCALE_W-1:0] chk_pt;
  logic                  at_chk;
  logic                  past_chk;
  logic                  bit_end;
  logic                  in_data_bits;

  assign chk_pt       = (prescale >> 1) + PRESCALE_W'(2);
  assign at_chk       = (edge_cnt == chk_pt);
  assign past_chk     = (edge_cnt == chk_pt + PRESCALE_W'(1));
  assign bit_end      = (edge_cnt == prescale);
  assign in_data_bits = (bit_cnt != BIT_CNT_W'(START_BIT)) &&
                        (bit_cnt <= BIT_CNT_W'(LAST_DATA_BIT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state decode and combinational counter/strobe outputs.
  always_comb begin
    // NOTE: every output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    new_frame   = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          new_frame = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = at_chk && (bit_cnt == BIT_CNT_W'(START_BIT));
        if (bit_end) begin
          state_d = glitch_q ? IDLE : DATA;
        end
      end

      DATA: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = at_chk && in_data_bits;
        if (bit_end && (bit_cnt == BIT_CNT_W'(LAST_DATA_BIT))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end

      PARITY: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = at_chk && (bit_cnt == BIT_CNT_W'(PARITY_BIT));
        if (bit_end) begin
          state_d = STOP;
        end
      end

      STOP: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = at_chk;
        // Leave right after the stop check so a start bit that follows
        // immediately is not missed.
        if (past_chk) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!RX_IN) begin
          new_frame = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Per-frame parity mode and checker result latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q  <= 1'b0;
      glitch_q  <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      if (new_frame) begin
        par_en_q  <= PAR_EN;
        glitch_q  <= 1'b0;
        par_err_q <= 1'b0;
        stp_err_q <= 1'b0;
      end
      if (strt_chk_en) glitch_q  <= strt_glitch;
      if (par_chk_en)  par_err_q <= par_err;
      if (stp_chk_en)  stp_err_q <= stp_err;
    end
  end

  // Registered frame result pulses and held error copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err_o  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state_q == DONE) begin
        // This frame's result wins over a back-to-back new_frame clear.
        data_valid <= !(par_err_q || stp_err_q);
        frame_err  <= par_err_q || stp_err_q;
        par_err_o  <= par_err_q;
        stp_err_o  <= stp_err_q;
      end else if (new_frame) begin
        par_err_o <= 1'b0;
        stp_err_o <= 1'b0;
      end
    end
  end

endmodule
